// File: rtl/zs_timer.sv
// zs_timer: TL-UL mtime/mtimecmp timer, single-outstanding responder.
// Define ZS_TIMER_HI_LATCH_EN for a coherent MTIME_HI shadow latched by LO reads.
package zs_timer_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;
endpackage

module zs_timer
  import zs_timer_pkg::*;
#(
  parameter int          PrescaleWidth = 12,
  parameter logic [63:0] CmpResetVal   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    intr_timer_o
);

  typedef enum logic {
    ST_IDLE,
    ST_RSP
  } st_e;

  localparam logic [PrescaleWidth-1:0] POne = 1;

  st_e st_q, st_d;

  logic [4:0]  addr;
  logic [2:0]  sel;
  logic [31:0] wdata;
  logic        accept;
  logic        is_get;
  logic        is_put;
  logic        bad;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  we;
  logic [31:0] rdata;
  logic [31:0] hi_rd;

  logic                     ctrl_en_q;
  logic [PrescaleWidth-1:0] prescale_q;
  logic [PrescaleWidth-1:0] pcnt_q;
  logic [63:0]              mtime_q;
  logic [63:0]              mtimecmp_q;
  logic                     intr_state_q;
  logic                     intr_enable_q;
  logic                     tick;
  logic                     cmp_hit;

  logic [2:0]  rsp_opcode_q;
  logic [1:0]  rsp_size_q;
  logic [7:0]  rsp_source_q;
  logic [31:0] rsp_data_q;
  logic        rsp_error_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:5]};

  assign addr   = tl_i.a_address[4:0];
  assign sel    = addr[4:2];
  assign wdata  = tl_i.a_data;
  assign accept = tl_i.a_valid & (st_q == ST_IDLE);
  assign is_get = (tl_i.a_opcode == GET);
  assign is_put = (tl_i.a_opcode == PUT_FULL);

  // PutPartialData and unknown opcodes fall out via !(is_get | is_put)
  assign bad = (addr[1:0] != 2'b00) | (tl_i.a_size != 2'd2) |
               (tl_i.a_mask != 4'hF) | ~(is_get | is_put);

  assign wr_en = accept & is_put & ~bad;
  assign rd_en = accept & is_get & ~bad;
  assign we    = wr_en ? (8'b1 << sel) : 8'b0;

`ifdef ZS_TIMER_HI_LATCH_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (we[3]) begin
      shadow_q <= wdata;
    end else if (rd_en && sel == 3'd2) begin
      shadow_q <= mtime_q[63:32];
    end
  end

  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rdata = '0;
    unique case (sel)
      3'd0: rdata = {31'b0, ctrl_en_q};
      3'd1: rdata = {{(32-PrescaleWidth){1'b0}}, prescale_q};
      3'd2: rdata = mtime_q[31:0];
      3'd3: rdata = hi_rd;
      3'd4: rdata = mtimecmp_q[31:0];
      3'd5: rdata = mtimecmp_q[63:32];
      3'd6: rdata = {31'b0, intr_state_q};
      3'd7: rdata = {31'b0, intr_enable_q};
      default: rdata = '0;
    endcase
  end

  assign tick    = ctrl_en_q & (pcnt_q == prescale_q);
  assign cmp_hit = (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q     <= 1'b0;
      prescale_q    <= '0;
      mtimecmp_q    <= CmpResetVal;
      intr_enable_q <= 1'b0;
    end else begin
      if (we[0]) ctrl_en_q <= wdata[0];
      if (we[1]) prescale_q <= wdata[PrescaleWidth-1:0];
      if (we[4]) mtimecmp_q[31:0] <= wdata;
      if (we[5]) mtimecmp_q[63:32] <= wdata;
      if (we[7]) intr_enable_q <= wdata[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else if (we[1]) begin
      pcnt_q <= '0;
    end else if (ctrl_en_q) begin
      pcnt_q <= tick ? '0 : pcnt_q + POne;
    end
  end

  // A half-write beats the tick and the other half skips the carry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q <= '0;
    end else if (we[2]) begin
      mtime_q[31:0] <= wdata;
    end else if (we[3]) begin
      mtime_q[63:32] <= wdata;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_state_q <= 1'b0;
    end else begin
      intr_state_q <= cmp_hit | (intr_state_q & ~(we[6] & wdata[0]));
    end
  end

  assign intr_timer_o = intr_state_q & intr_enable_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_opcode_q <= ACK;
      rsp_size_q   <= '0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else if (accept) begin
      rsp_opcode_q <= is_get ? ACK_DATA : ACK;
      rsp_size_q   <= tl_i.a_size;
      rsp_source_q <= tl_i.a_source;
      rsp_data_q   <= rd_en ? rdata : 32'b0;
      rsp_error_q  <= bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st_q <= ST_IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (tl_i.a_valid) st_d = ST_RSP;
      ST_RSP:  if (tl_i.d_ready) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (st_q == ST_IDLE);
    tl_o.d_valid  = (st_q == ST_RSP);
    tl_o.d_opcode = rsp_opcode_q;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_source_q;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_error  = rsp_error_q;
  end

endmodule

// File: tb/tb_zs_timer.sv
// tb_zs_timer: vector table, directed corner sequences and random traffic
// checked against a cycle-level register model of the timer.
module tb_zs_timer;
  import zs_timer_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t h;
  tl_d2h_t d;
  logic    intr;

  always #5 clk = ~clk;

  zs_timer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tl_i        (h),
    .tl_o        (d),
    .intr_timer_o(intr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    logic        err;
    logic [31:0] data;
    logic [7:0]  src;
    logic [1:0]  sz;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        e;
  logic        m_pend, m_en, m_is, m_ie;
  logic [11:0] m_presc;
  int          m_pcnt;
  logic [63:0] m_mtime, m_cmp, nm;
  logic [31:0] m_sh, wd;
  logic        acc, bad, w, rdn, hit, tick;
  logic [2:0]  r;

  function automatic logic [31:0] mread(input logic [2:0] ri);
    case (ri)
      3'd0: return {31'b0, m_en};
      3'd1: return {20'b0, m_presc};
      3'd2: return m_mtime[31:0];
`ifdef ZS_TIMER_HI_LATCH_EN
      3'd3: return m_sh;
`else
      3'd3: return m_mtime[63:32];
`endif
      3'd4: return m_cmp[31:0];
      3'd5: return m_cmp[63:32];
      3'd6: return {31'b0, m_is};
      default: return {31'b0, m_ie};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_en = 0; m_is = 0; m_ie = 0; m_presc = 0; m_pcnt = 0;
      m_mtime = 0; m_cmp = '1; m_sh = 0;
      q.delete();
    end else begin
      acc = h.a_valid && !m_pend;
      r   = h.a_address[4:2];
      wd  = h.a_data;
      bad = (h.a_address[1:0] != 2'b00) || (h.a_size != 2'd2) ||
            (h.a_mask != 4'hF) ||
            !(h.a_opcode == GET || h.a_opcode == PUT_FULL);
      w   = acc && !bad && h.a_opcode == PUT_FULL;
      rdn = acc && !bad && h.a_opcode == GET;
      if (acc) begin
        e.op   = (h.a_opcode == GET) ? ACK_DATA : ACK;
        e.err  = bad;
        e.data = rdn ? mread(r) : 32'b0;
        e.src  = h.a_source;
        e.sz   = h.a_size;
        q.push_back(e);
        m_pend = 1;
      end else if (m_pend && h.d_ready) begin
        m_pend = 0;
        void'(q.pop_front());
      end
      hit  = (m_mtime >= m_cmp);
      tick = m_en && (m_pcnt == int'(m_presc));
      nm   = tick ? m_mtime + 64'd1 : m_mtime;
      if (w && r == 3'd2) nm = {m_mtime[63:32], wd};
      if (w && r == 3'd3) nm = {wd, m_mtime[31:0]};
      if (w && r == 3'd1) m_pcnt = 0;
      else if (m_en) m_pcnt = tick ? 0 : m_pcnt + 1;
`ifdef ZS_TIMER_HI_LATCH_EN
      if (rdn && r == 3'd2) m_sh = m_mtime[63:32];
      if (w && r == 3'd3) m_sh = wd;
`endif
      m_is = hit || (m_is && !(w && r == 3'd6 && wd[0]));
      m_mtime = nm;
      if (w && r == 3'd0) m_en = wd[0];
      if (w && r == 3'd1) m_presc = wd[11:0];
      if (w && r == 3'd4) m_cmp[31:0] = wd;
      if (w && r == 3'd5) m_cmp[63:32] = wd;
      if (w && r == 3'd7) m_ie = wd[0];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_ready", 64'(d.a_ready), 64'(!m_pend));
      chk("d_valid", 64'(d.d_valid), 64'(m_pend));
      chk("intr", 64'(intr), 64'(m_is & m_ie));
      if (d.d_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          chk("d_opcode", 64'(d.d_opcode), 64'(q[0].op));
          chk("d_error", 64'(d.d_error), 64'(q[0].err));
          chk("d_data", 64'(d.d_data), 64'(q[0].data));
          chk("d_source", 64'(d.d_source), 64'(q[0].src));
          chk("d_size", 64'(d.d_size), 64'(q[0].sz));
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] wdat, input logic [3:0] m,
                     input logic [1:0] sz, input int hold,
                     output logic [31:0] rdat, output logic er);
    int n;
    h.a_valid   = 1'b1;
    h.a_opcode  = op;
    h.a_address = a;
    h.a_data    = wdat;
    h.a_mask    = m;
    h.a_size    = sz;
    h.a_source  = 8'($urandom);
    n = 0;
    @(negedge clk);
    while (!d.a_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("accept_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1 h.a_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!d.d_valid && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("resp_timeout", 64'(1), 64'(0));
    rdat = d.d_data;
    er   = d.d_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_d_valid", 64'(d.d_valid), 64'(1));
      chk("hold_d_data", 64'(d.d_data), 64'(rdat));
      chk("hold_a_ready", 64'(d.a_ready), 64'(0));
    end
    h.d_ready = 1'b1;
    @(posedge clk);
    #1 h.d_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wdat);
    logic [31:0] rd_d;
    logic        er;
    bus(PUT_FULL, a, wdat, 4'hF, 2'd2, 0, rd_d, er);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] rdat);
    logic er;
    bus(GET, a, 32'h0, 4'hF, 2'd2, 0, rdat, er);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [1:0]  sz;
    logic        eerr;
    logic [31:0] edata;
  } vec_t;

  vec_t        tv[15];
  logic [31:0] v, v2, lo, hi;
  logic        er;
  int          n;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{GET, 32'h14, 0, 4'hF, 2'd2, 0, 32'hFFFF_FFFF};
    tv[1]  = '{GET, 32'h10, 0, 4'hF, 2'd2, 0, 32'hFFFF_FFFF};
    tv[2]  = '{GET, 32'h08, 0, 4'hF, 2'd2, 0, 32'h0};
    tv[3]  = '{GET, 32'h00, 0, 4'hF, 2'd2, 0, 32'h0};
    tv[4]  = '{GET, 32'h02, 0, 4'hF, 2'd2, 1, 32'h0};
    tv[5]  = '{GET, 32'h00, 0, 4'hF, 2'd1, 1, 32'h0};
    tv[6]  = '{PUT_PARTIAL, 32'h00, 1, 4'h3, 2'd2, 1, 32'h0};
    tv[7]  = '{PUT_FULL, 32'h00, 1, 4'h3, 2'd2, 1, 32'h0};
    tv[8]  = '{3'd3, 32'h00, 1, 4'hF, 2'd2, 1, 32'h0};
    tv[9]  = '{GET, 32'h00, 0, 4'hF, 2'd2, 0, 32'h0};
    tv[10] = '{PUT_FULL, 32'h04, 32'hFFFF_FFFF, 4'hF, 2'd2, 0, 32'h0};
    tv[11] = '{GET, 32'h04, 0, 4'hF, 2'd2, 0, 32'h0000_0FFF};
    tv[12] = '{GET, 32'h124, 0, 4'hF, 2'd2, 0, 32'h0000_0FFF};
    tv[13] = '{PUT_FULL, 32'h04, 0, 4'hF, 2'd2, 0, 32'h0};
    tv[14] = '{GET, 32'h1C, 0, 4'hF, 2'd2, 0, 32'h0};

    h = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_intr", 64'(intr), 64'(0));
    chk("rst_a_ready", 64'(d.a_ready), 64'(1));
    chk("rst_d_valid", 64'(d.d_valid), 64'(0));
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      bus(tv[i].op, tv[i].addr, tv[i].wd, tv[i].m, tv[i].sz, 0, v, er);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tv[i].eerr));
      chk($sformatf("vec%0d_data", i), 64'(v), 64'(tv[i].edata));
    end

    // d_ready back-pressure
    bus(GET, 32'h14, 0, 4'hF, 2'd2, 5, v, er);
    chk("hold_value", 64'(v), 64'hFFFF_FFFF);

    // prescaled counting then freeze
    wr(32'h04, 3);
    wr(32'h00, 1);
    repeat (40) @(posedge clk);
    #1 wr(32'h00, 0);
    rd(32'h08, v);
    chk("presc_count_range", 64'(v >= 9 && v <= 11), 64'(1));
    repeat (5) @(posedge clk);
    #1 rd(32'h08, v2);
    chk("frozen_stable", 64'(v2), 64'(v));

    // compare interrupt and W1C
    wr(32'h04, 0);
    wr(32'h08, 0);
    wr(32'h0C, 0);
    wr(32'h14, 0);
    wr(32'h10, 20);
    wr(32'h1C, 1);
    wr(32'h00, 1);
    n = 0;
    @(negedge clk);
    while (!intr && n < 200) begin n++; @(negedge clk); end
    chk("intr_rise", 64'(intr), 64'(1));
    @(posedge clk);
    #1 wr(32'h18, 1);
    rd(32'h18, v);
    chk("w1c_set_wins", 64'(v), 64'(1));
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h18, 1);
    rd(32'h18, v);
    chk("w1c_cleared", 64'(v), 64'(0));
    chk("intr_cleared", 64'(intr), 64'(0));
    wr(32'h00, 0);

    // single tick across the 32-bit carry
    wr(32'h0C, 0);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h04, 1);
    wr(32'h00, 1);
    wr(32'h00, 0);
    rd(32'h0C, hi);
    rd(32'h08, lo);
    chk("carry_hi", 64'(hi), 64'(1));
    chk("carry_lo", 64'(lo), 64'(0));

    // LO read just before carry, HI read just after
    wr(32'h04, 0);
    wr(32'h0C, 0);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h00, 1);
    rd(32'h08, lo);
    rd(32'h0C, hi);
    wr(32'h00, 0);
    chk("latch_lo", 64'(lo), 64'hFFFF_FFFF);
`ifdef ZS_TIMER_HI_LATCH_EN
    chk("latch_hi", 64'(hi), 64'(0));
`else
    chk("latch_hi", 64'(hi), 64'(1));
`endif

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      int          sel, kind, hold;
      logic [31:0] a, dat;
      sel  = $urandom_range(0, 7);
      kind = $urandom_range(0, 19);
      hold = $urandom_range(0, 2);
      a    = {$urandom_range(0, 7), 5'(sel << 2)};
      dat  = $urandom;
      case (sel)
        0, 6, 7: dat = 32'($urandom_range(0, 1));
        1: dat = 32'($urandom_range(0, 3));
        2: dat = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                              : 32'($urandom_range(0, 100));
        3, 5: dat = 32'($urandom_range(0, 1));
        4: dat = 32'($urandom_range(0, 200));
        default: ;
      endcase
      if (kind < 9) bus(GET, a, 0, 4'hF, 2'd2, hold, v, er);
      else if (kind < 18) bus(PUT_FULL, a, dat, 4'hF, 2'd2, hold, v, er);
      else if (kind == 18) bus(PUT_PARTIAL, a, dat, 4'h3, 2'd2, hold, v, er);
      else bus(GET, a | 32'h2, 0, 4'hF, 2'd2, hold, v, er);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // reset while a response is outstanding
    wr(32'h08, 32'h55);
    wr(32'h10, 32'h10);
    wr(32'h00, 1);
    h.a_valid   = 1'b1;
    h.a_opcode  = GET;
    h.a_address = 32'h08;
    h.a_size    = 2'd2;
    h.a_mask    = 4'hF;
    @(negedge clk);
    @(posedge clk);
    #1 h.a_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_d_valid", 64'(d.d_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drop_d_valid", 64'(d.d_valid), 64'(0));
    chk("rst_a_ready", 64'(d.a_ready), 64'(1));
    chk("rst_intr_low", 64'(intr), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 rd(32'h08, v);
    chk("rst_mtime_lo", 64'(v), 64'(0));
    rd(32'h10, v);
    chk("rst_cmp_lo", 64'(v), 64'hFFFF_FFFF);
    rd(32'h14, v);
    chk("rst_cmp_hi", 64'(v), 64'hFFFF_FFFF);
    rd(32'h00, v);
    chk("rst_ctrl", 64'(v), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
